channel_buffer: RTL and testbench

- Per-channel packet queue that sits directly upstream of the four-way output reader.
- Accepts 12-bit packets from the packet source and holds up to DEPTH entries.
- Presents the head packet and the occupancy count to the reader, and retires the head when the reader selects this channel.
- Four instances feed the reader, one per channel; each instance keeps its own received and dropped statistics.

---
 rtl/chan_pkg.sv | 16 +
 rtl/sat_counter.sv | 34 +++
 rtl/channel_buffer.sv | 137 +++++++++++++
 tb/tb_channel_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pkg.sv
// Shared constants for the four-channel packet path.
// Build option: CHANNEL_BUFFER_UNDERFLOW_EN adds underflow statistics.
package chan_pkg;

    localparam int DATA_W       = 12;
    localparam int DEPTH        = 4;
    localparam int CNT_W        = 3;
    localparam int STAT_W       = 16;
    localparam int NUM_CHANNELS = 4;

    localparam logic [1:0] CH_ID0 = 2'b00;
    localparam logic [1:0] CH_ID1 = 2'b01;
    localparam logic [1:0] CH_ID2 = 2'b10;
    localparam logic [1:0] CH_ID3 = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
// Build option: none.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    // Next value: step by one unless already at the ceiling.
    always_comb begin
        cnt_nxt = cnt;
        if (inc && (cnt != '1)) begin
            cnt_nxt = cnt + W'(1);
        end
    end

    // Counter register, reloaded every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign count = cnt;

endmodule

// File: rtl/channel_buffer.sv
// Per-channel packet queue feeding the output reader.
// Build option: CHANNEL_BUFFER_UNDERFLOW_EN adds underflow/underflow_seen.
module channel_buffer #(
    parameter int DATA_W = chan_pkg::DATA_W,
    parameter int DEPTH  = chan_pkg::DEPTH,
    parameter int CNT_W  = chan_pkg::CNT_W,
    parameter int STAT_W = chan_pkg::STAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              rd_sel,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic              full,
    output logic              empty,
    output logic              pop_ack,
`ifdef CHANNEL_BUFFER_UNDERFLOW_EN
    output logic [STAT_W-1:0] underflow,
    output logic              underflow_seen,
`endif
    output logic [STAT_W-1:0] received,
    output logic [STAT_W-1:0] dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  occ;
    logic              rd_sel_q;

    logic pop_req;
    logic do_pop;
    logic do_push;
    logic do_drop;

    assign full  = (occ == FULL_CNT);
    assign empty = (occ == '0);

    // Pop decision uses the pre-cycle count; a full queue takes a
    // push in the same cycle that a pop frees a slot.
    always_comb begin
        pop_req = rd_sel & ~rd_sel_q;
        do_pop  = pop_req & ~empty;
        do_push = push & (~full | do_pop);
        do_drop = push & full & ~do_pop;
    end

    // Select edge detector and retire strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_q <= 1'b0;
            pop_ack  <= 1'b0;
        end else begin
            rd_sel_q <= rd_sel;
            pop_ack  <= do_pop;
        end
    end

    // Circular storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Registered occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign occupancy = occ;
    assign head_data = empty ? '0 : mem[rd_ptr];

    sat_counter #(.W(STAT_W)) u_received (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_push),
        .count (received)
    );

    sat_counter #(.W(STAT_W)) u_dropped (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_drop),
        .count (dropped)
    );

`ifdef CHANNEL_BUFFER_UNDERFLOW_EN
    logic do_under;
    assign do_under = pop_req & empty;

    sat_counter #(.W(STAT_W)) u_underflow (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_under),
        .count (underflow)
    );

    // Sticky flag: set on first underflow, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_seen <= 1'b0;
        end else if (do_under) begin
            underflow_seen <= 1'b1;
        end
    end
`else
    logic unused_under;
    assign unused_under = pop_req & empty;
`endif

endmodule

// File: tb/tb_channel_buffer.sv
// Self-checking bench for channel_buffer.
// Build option: CHANNEL_BUFFER_UNDERFLOW_EN enables the underflow sequence.
module tb_channel_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [11:0] push_data;
    logic        rd_sel;
    logic [11:0] head_data;
    logic [2:0]  occupancy;
    logic        full;
    logic        empty;
    logic        pop_ack;
    logic [15:0] received;
    logic [15:0] dropped;
`ifdef CHANNEL_BUFFER_UNDERFLOW_EN
    logic [15:0] underflow;
    logic        underflow_seen;
`endif

    always #5 clk = ~clk;

    channel_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (push),
        .push_data      (push_data),
        .rd_sel         (rd_sel),
        .head_data      (head_data),
        .occupancy      (occupancy),
        .full           (full),
        .empty          (empty),
        .pop_ack        (pop_ack),
`ifdef CHANNEL_BUFFER_UNDERFLOW_EN
        .underflow      (underflow),
        .underflow_seen (underflow_seen),
`endif
        .received       (received),
        .dropped        (dropped)
    );

    typedef struct {
        logic        push;
        logic [11:0] data;
        logic        rd;
        logic [2:0]  occ;
        logic        full;
        logic        empty;
        logic [11:0] head;
        logic        ack;
        logic [15:0] rcv;
        logic [15:0] drp;
    } vec_t;

    vec_t tbl [15];

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] model_q [$];
    logic [11:0] sb_q [$];
    logic        prev_rd;
    int          acks;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        push      = 1'b0;
        push_data = '0;
        rd_sel    = 1'b0;
        rst_n     = 1'b0;
        model_q.delete();
        sb_q.delete();
        prev_rd = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle; the model predicts retire events and the
    // scoreboard checks the head shown with each pop_ack.
    task automatic cyc(input logic p, input logic [11:0] d,
                       input logic r);
        logic pop_ev;
        logic acc;
        pop_ev = r && !prev_rd && (model_q.size() > 0);
        acc    = p && ((model_q.size() < 4) || pop_ev);
        if (pop_ev) void'(model_q.pop_front());
        if (acc) model_q.push_back(d);
        if (pop_ev) sb_q.push_back(model_q.size() > 0 ? model_q[0] : 12'h0);
        prev_rd   = r;
        push      = p;
        push_data = d;
        rd_sel    = r;
        @(posedge clk);
        #1;
        chk("pop_ack", {31'b0, pop_ack}, {31'b0, pop_ev});
        if (pop_ack) begin
            acks++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_head: pop_ack with nothing expected");
            end else begin
                chk("sb_head", {20'b0, head_data}, {20'b0, sb_q.pop_front()});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 12'hA01, 1'b0, 3'd1, 1'b0, 1'b0, 12'hA01, 1'b0, 16'd1, 16'd0};
        tbl[1]  = '{1'b1, 12'hB02, 1'b0, 3'd2, 1'b0, 1'b0, 12'hA01, 1'b0, 16'd2, 16'd0};
        tbl[2]  = '{1'b1, 12'hC03, 1'b0, 3'd3, 1'b0, 1'b0, 12'hA01, 1'b0, 16'd3, 16'd0};
        tbl[3]  = '{1'b1, 12'hD04, 1'b0, 3'd4, 1'b1, 1'b0, 12'hA01, 1'b0, 16'd4, 16'd0};
        tbl[4]  = '{1'b1, 12'hEEE, 1'b0, 3'd4, 1'b1, 1'b0, 12'hA01, 1'b0, 16'd4, 16'd1};
        tbl[5]  = '{1'b0, 12'h000, 1'b1, 3'd3, 1'b0, 1'b0, 12'hB02, 1'b1, 16'd4, 16'd1};
        tbl[6]  = '{1'b0, 12'h000, 1'b0, 3'd3, 1'b0, 1'b0, 12'hB02, 1'b0, 16'd4, 16'd1};
        tbl[7]  = '{1'b0, 12'h000, 1'b1, 3'd2, 1'b0, 1'b0, 12'hC03, 1'b1, 16'd4, 16'd1};
        tbl[8]  = '{1'b0, 12'h000, 1'b0, 3'd2, 1'b0, 1'b0, 12'hC03, 1'b0, 16'd4, 16'd1};
        tbl[9]  = '{1'b0, 12'h000, 1'b1, 3'd1, 1'b0, 1'b0, 12'hD04, 1'b1, 16'd4, 16'd1};
        tbl[10] = '{1'b0, 12'h000, 1'b0, 3'd1, 1'b0, 1'b0, 12'hD04, 1'b0, 16'd4, 16'd1};
        tbl[11] = '{1'b0, 12'h000, 1'b1, 3'd0, 1'b0, 1'b1, 12'h000, 1'b1, 16'd4, 16'd1};
        tbl[12] = '{1'b0, 12'h000, 1'b0, 3'd0, 1'b0, 1'b1, 12'h000, 1'b0, 16'd4, 16'd1};
        tbl[13] = '{1'b0, 12'h000, 1'b1, 3'd0, 1'b0, 1'b1, 12'h000, 1'b0, 16'd4, 16'd1};
        tbl[14] = '{1'b0, 12'h000, 1'b0, 3'd0, 1'b0, 1'b1, 12'h000, 1'b0, 16'd4, 16'd1};

        acks = 0;
        do_reset();
        #1;
        chk("rst_occ", {29'b0, occupancy}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_head", {20'b0, head_data}, 32'd0);

        // Fill, overflow, ordered drain, pop on empty.
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].push, tbl[i].data, tbl[i].rd);
            chk($sformatf("v%0d_occ", i), {29'b0, occupancy}, {29'b0, tbl[i].occ});
            chk($sformatf("v%0d_full", i), {31'b0, full}, {31'b0, tbl[i].full});
            chk($sformatf("v%0d_empty", i), {31'b0, empty}, {31'b0, tbl[i].empty});
            chk($sformatf("v%0d_head", i), {20'b0, head_data}, {20'b0, tbl[i].head});
            chk($sformatf("v%0d_ack", i), {31'b0, pop_ack}, {31'b0, tbl[i].ack});
            chk($sformatf("v%0d_rcv", i), {16'b0, received}, {16'b0, tbl[i].rcv});
            chk($sformatf("v%0d_drp", i), {16'b0, dropped}, {16'b0, tbl[i].drp});
        end

        // Reset asserted mid-run with three packets queued.
        cyc(1'b1, 12'h111, 1'b0);
        cyc(1'b1, 12'h222, 1'b0);
        cyc(1'b1, 12'h333, 1'b0);
        chk("pre_rst_occ", {29'b0, occupancy}, 32'd3);
        push = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_occ", {29'b0, occupancy}, 32'd0);
        chk("mid_rst_head", {20'b0, head_data}, 32'd0);
        chk("mid_rst_empty", {31'b0, empty}, 32'd1);
        chk("mid_rst_rcv", {16'b0, received}, 32'd0);
        chk("mid_rst_drp", {16'b0, dropped}, 32'd0);
        do_reset();

        // Push and pop together while full.
        cyc(1'b1, 12'hA01, 1'b0);
        cyc(1'b1, 12'hB02, 1'b0);
        cyc(1'b1, 12'hC03, 1'b0);
        cyc(1'b1, 12'hD04, 1'b0);
        cyc(1'b1, 12'hEEE, 1'b1);
        chk("fpp_drp", {16'b0, dropped}, 32'd0);
        chk("fpp_occ", {29'b0, occupancy}, 32'd4);
        chk("fpp_rcv", {16'b0, received}, 32'd5);
        chk("fpp_head", {20'b0, head_data}, 32'h0B02);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 12'h0, 1'b0);
            cyc(1'b0, 12'h0, 1'b1);
        end
        chk("fpp_4th", {20'b0, head_data}, 32'h0EEE);
        cyc(1'b0, 12'h0, 1'b0);

        // Select held high retires exactly one packet.
        do_reset();
        cyc(1'b1, 12'h5A5, 1'b0);
        cyc(1'b1, 12'h6B6, 1'b0);
        chk("hold_occ0", {29'b0, occupancy}, 32'd2);
        acks = 0;
        for (int i = 0; i < 1000; i++) cyc(1'b0, 12'h0, 1'b1);
        chk("hold_acks", acks, 32'd1);
        chk("hold_occ1", {29'b0, occupancy}, 32'd1);
        chk("hold_head", {20'b0, head_data}, 32'h06B6);
        cyc(1'b0, 12'h0, 1'b0);

        // Statistics saturation.
        do_reset();
        force dut.u_received.cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.u_received.cnt;
        #1;
        chk("sat_pre", {16'b0, received}, 32'h0000FFFE);
        cyc(1'b1, 12'h101, 1'b0);
        cyc(1'b0, 12'h0, 1'b1);
        chk("sat_1", {16'b0, received}, 32'h0000FFFF);
        cyc(1'b1, 12'h202, 1'b0);
        cyc(1'b0, 12'h0, 1'b1);
        cyc(1'b1, 12'h303, 1'b0);
        chk("sat_2", {16'b0, received}, 32'h0000FFFF);
        chk("sat_occ", {29'b0, occupancy}, 32'd1);

`ifdef CHANNEL_BUFFER_UNDERFLOW_EN
        // Two select edges against an empty queue.
        do_reset();
        chk("uf_rst", {16'b0, underflow}, 32'd0);
        acks = 0;
        cyc(1'b0, 12'h0, 1'b1);
        cyc(1'b0, 12'h0, 1'b0);
        cyc(1'b0, 12'h0, 1'b1);
        cyc(1'b0, 12'h0, 1'b0);
        chk("uf_cnt", {16'b0, underflow}, 32'd2);
        chk("uf_seen", {31'b0, underflow_seen}, 32'd1);
        chk("uf_acks", acks, 32'd0);
`endif

        chk("sb_left", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
